// File: rtl/serial_channel_arbiter.sv
// Round-robin arbiter muxing N_CH serial channels into one deserializer, one LENGTH-bit word per grant.
// Optional stall abort is compiled in when ARB_TIMEOUT_EN is defined.
module serial_channel_arbiter #(
    parameter int N_CH    = 4,
    parameter int LENGTH  = 24,
    parameter int TIMEOUT = 64,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [N_CH-1:0] iv_req,
    input  logic [N_CH-1:0] iv_din,
    input  logic [N_CH-1:0] iv_din_valid,
    output logic [N_CH-1:0] ov_ready,
    output logic [N_CH-1:0] ov_grant,
    output logic            o_din,
    output logic            o_din_valid,
    input  logic            i_des_ready,
    input  logic            i_word_valid,
    output logic [CH_W-1:0] o_word_ch,
    output logic            o_busy,
    output logic            o_timeout,
    output logic [1:0]      o_state_dbg
);

    localparam int CNT_W = $clog2(LENGTH) + 1;

    if (N_CH < 1 || N_CH > 16 || LENGTH < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("serial_channel_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAKE  = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   word_ch_q, word_ch_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   pick_w;
    logic [CH_W-1:0]   next_rr_w;
    logic              accept_w;
    logic              abort_w;
    logic              stall_hit_w;

    // Handshake: a bit moves when the granted channel is valid and the deserializer
    // is ready; gated by i_en so the forwarded count always matches cnt_q.
    assign accept_w  = (state_q == XFER) && iv_din_valid[word_ch_q] && i_des_ready && i_en;
    assign next_rr_w = (word_ch_q == CH_W'(N_CH - 1)) ? '0 : word_ch_q + 1'b1;

    // Iterate downwards so the lowest offset from rr_q wins.
    always_comb begin
        pick_w = rr_q;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (iv_req[CH_W'((int'(rr_q) + i) % N_CH)]) begin
                pick_w = CH_W'((int'(rr_q) + i) % N_CH);
            end
        end
    end

    always_comb begin
        o_din       = 1'b0;
        o_din_valid = 1'b0;
        ov_ready    = '0;
        case (state_q)
            WAKE: o_din_valid = 1'b1;
            XFER: begin
                o_din               = iv_din[word_ch_q];
                o_din_valid         = accept_w;
                ov_ready[word_ch_q] = accept_w;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        word_ch_d = word_ch_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        abort_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|iv_req) begin
                    state_d         = WAKE;
                    word_ch_d       = pick_w;
                    grant_d         = '0;
                    grant_d[pick_w] = 1'b1;
                    cnt_d           = '0;
                end
            end
            WAKE: begin
                if (i_des_ready) state_d = XFER;
            end
            XFER: begin
                if (accept_w) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(LENGTH)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (i_word_valid) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = next_rr_w;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // A normal transition in the same cycle takes precedence over a stall abort.
        if (stall_hit_w && state_d == state_q) begin
            abort_w = 1'b1;
            state_d = IDLE;
            grant_d = '0;
            rr_d    = next_rr_w;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            word_ch_q <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
        end else if (i_en) begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            word_ch_q <= word_ch_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q, stall_d;

    assign stall_hit_w = (state_q != IDLE) && !accept_w && (stall_q == STALL_W'(TIMEOUT - 1));
    assign o_timeout   = abort_w && i_en && !i_rst;

    always_comb begin
        if (state_q == IDLE || accept_w || state_d != state_q) stall_d = '0;
        else                                                   stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)     stall_q <= '0;
        else if (i_en) stall_q <= stall_d;
    end
`else
    assign stall_hit_w = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    assign ov_grant    = grant_q;
    assign o_word_ch   = word_ch_q;
    assign o_busy      = (state_q != IDLE);
    assign o_state_dbg = state_q;

endmodule
